// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one byte-wide FIFO write port among N_REQ producers.
// Grants bounded bursts, stalls on full, and latches a sticky error on FIFO overflow.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 w_en,
  output logic [7:0]           data_w,
  input  logic                 full,
  input  logic                 overflow,
  output logic                 err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_MAX - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   last_owner_reg, last_owner_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic               err_reg;

  logic [IDX_W-1:0]   search_base, cand, pick_idx;
  logic               pick_valid, owner_req, xfer, burst_done, withdraw;
  logic [7:0]         byte_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign byte_arr[gi] = req_data[8*gi +: 8];
      assign ack[gi]      = xfer & grant_reg[gi];
    end
  endgenerate

  // While serving, the next search starts after the current owner, which becomes last_owner on exit.
  assign search_base = (state_reg == SERVE) ? owner_reg : last_owner_reg;

  // Scan farthest candidate first so the nearest set bit after search_base wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(search_base) + k) % N_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_req  = req[owner_reg];
  assign xfer       = (state_reg == SERVE) && owner_req && !full;
  assign burst_done = xfer && (burst_cnt_reg == CNT_LAST);
  assign withdraw   = (state_reg == SERVE) && !owner_req;

  assign busy   = (state_reg == SERVE);
  assign grant  = grant_reg;
  assign w_en   = xfer;
  assign data_w = (state_reg == SERVE) ? byte_arr[owner_reg] : 8'h00;
  assign err    = err_reg;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    burst_cnt_next  = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next     = SERVE;
          owner_next     = pick_idx;
          grant_next     = N_REQ'(1) << pick_idx;
          burst_cnt_next = '0;
        end
      end
      SERVE: begin
        if (withdraw || burst_done) begin
          last_owner_next = owner_reg;
          burst_cnt_next  = '0;
          if (pick_valid) begin
            owner_next = pick_idx;
            grant_next = N_REQ'(1) << pick_idx;
          end else begin
            state_next = IDLE;
            grant_next = '0;
          end
        end else if (xfer) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      owner_reg      <= '0;
      last_owner_reg <= LAST_INIT;
      burst_cnt_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      burst_cnt_reg  <= burst_cnt_next;
      // The arbiter never writes into a full FIFO, so overflow means an outside fault.
      err_reg        <= err_reg | overflow;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle comparison against an integer-level
// round-robin model, plus literal expectations taken from the scenario walkthroughs.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int BM = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic           full, overflow;
  logic [N-1:0]   ack, grant;
  logic           busy, w_en, err;
  logic [7:0]     data_w;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .busy(busy), .w_en(w_en), .data_w(data_w),
    .full(full), .overflow(overflow), .err(err)
  );

  // Model: owner index (-1 = nobody), previous owner, bytes sent this burst, sticky error.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;
  bit m_err   = 1'b0;

  int checks = 0;
  int errors = 0;
  int ack_cnt [N] = '{default: 0};
  int wen_cnt = 0;

  function automatic int next_from(input int base, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (overflow) m_err = 1'b1;
      if (m_owner < 0) begin
        m_owner = next_from(m_last, req);
        m_cnt = 0;
      end else if (!req[m_owner] || (!full && m_cnt + 1 == BM)) begin
        m_last  = m_owner;
        m_owner = next_from(m_owner, req);
        m_cnt   = 0;
      end else if (!full) begin
        m_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_cycle();
    logic       e_busy, e_x;
    logic [N-1:0] e_grant;
    logic [7:0] e_data;
    e_busy  = (m_owner >= 0);
    e_grant = e_busy ? N'(1) << m_owner : '0;
    e_x     = e_busy && req[m_owner] && !full;
    e_data  = e_busy ? req_data[8*m_owner +: 8] : 8'h00;
    check("cyc_grant", 32'(grant), 32'(e_grant));
    check("cyc_busy",  32'(busy),  32'(e_busy));
    check("cyc_w_en",  32'(w_en),  32'(e_x));
    check("cyc_ack",   32'(ack),   32'(e_x ? e_grant : '0));
    check("cyc_data",  32'(data_w), 32'(e_data));
    check("cyc_err",   32'(err),   32'(m_err));
    for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
    if (w_en) wen_cnt++;
    $display("t=%0t req=%b full=%b grant=%b ack=%b w_en=%b data=%h err=%b",
             $time, req, full, grant, ack, w_en, data_w, err);
  endtask

  // Compare at the falling edge, then move to 2ns after the next rising edge to drive.
  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int base0, basew, b [N];

  initial begin
    req = '0; full = 1'b0; overflow = 1'b0;
    req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA5};
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_err",   32'(err),   32'h0);
    tick(); tick();
    rst = 1'b0;

    // Single producer: grant after one edge, continuous traffic with self re-grant.
    req = 4'b0001;
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_wen",   32'(w_en),  32'h1);
    check("t1_data",  32'(data_w), 32'hA5);
    base0 = ack_cnt[0];
    repeat (5) tick();
    req = 4'b0000;
    tick();
    check("t1_acks",  32'(ack_cnt[0] - base0), 32'd5);
    check("t1_idle",  32'(grant), 32'h0);

    // All requesting: four-byte bursts rotating 0,1,2,3,0 with no gaps.
    do_reset();
    req = 4'b1111;
    tick();
    basew = wen_cnt;
    for (int i = 0; i < N; i++) b[i] = ack_cnt[i];
    for (int k = 0; k < N; k++) begin
      check("t2_grant", 32'(grant), 32'(1 << k));
      repeat (4) tick();
    end
    check("t2_wrap", 32'(grant), 32'h1);
    check("t2_wen16", 32'(wen_cnt - basew), 32'd16);
    for (int i = 0; i < N; i++) check("t2_acks", 32'(ack_cnt[i] - b[i]), 32'd4);

    // Full stall mid-burst on producer 1.
    do_reset();
    req = 4'b1010;
    tick();
    check("t3_grant", 32'(grant), 32'h2);
    b[1] = ack_cnt[1];
    tick(); tick();
    check("t3_two", 32'(ack_cnt[1] - b[1]), 32'd2);
    full = 1'b1;
    repeat (3) tick();
    check("t3_hold", 32'(grant), 32'h2);
    check("t3_nowen", 32'(w_en), 32'h0);
    check("t3_stall", 32'(ack_cnt[1] - b[1]), 32'd2);
    full = 1'b0;
    tick(); tick();
    check("t3_four", 32'(ack_cnt[1] - b[1]), 32'd4);
    check("t3_rot",  32'(grant), 32'h8);

    // Producer 2 withdraws after one byte.
    do_reset();
    req = 4'b1100;
    tick();
    check("t4_grant", 32'(grant), 32'h4);
    b[2] = ack_cnt[2];
    tick();
    req = 4'b1000;
    tick();
    check("t4_next", 32'(grant), 32'h8);
    check("t4_one",  32'(ack_cnt[2] - b[2]), 32'd1);

    // Overflow pulse sets a sticky error; traffic continues.
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    check("t5_err", 32'(err), 32'h1);
    repeat (5) tick();
    check("t5_sticky", 32'(err), 32'h1);
    check("t5_traffic", 32'(w_en), 32'h1);

    // Asynchronous reset mid-burst, then priority restarts from producer 0.
    rst = 1'b1;
    #1;
    check("t6_grant0", 32'(grant), 32'h0);
    check("t6_wen0",   32'(w_en),  32'h0);
    check("t6_ack0",   32'(ack),   32'h0);
    check("t6_err0",   32'(err),   32'h0);
    req = 4'b0110;
    #1;
    rst = 1'b0;
    tick();
    check("t6_first", 32'(grant), 32'h2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single byte-wide write port of the 16-deep byte FIFO among N_REQ byte producers.
- Grants one producer at a time for a bounded burst of bytes.
- Stalls on FIFO full and raises a sticky error if the FIFO ever reports overflow.
- Sits directly in front of the FIFO write interface (w_en/data_w/full/overflow).

Parameters:
N_REQ, 4, number of producers (2..8)
BURST_MAX, 4, max bytes accepted per grant before rotating (1..16)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req  input  N_REQ  per-producer byte valid; bit i belongs to producer i
req_data  input  8*N_REQ  producer i byte on [8i+7:8i]
ack  output  N_REQ  one-hot pulse: producer i byte consumed this cycle
grant  output  N_REQ  one-hot current owner, registered; 0 when idle
busy  output  1  high while in SERVE
w_en  output  1  FIFO write enable
data_w  output  8  FIFO write data
full  input  1  FIFO full
overflow  input  1  FIFO overflow flag
err  output  1  sticky: overflow seen

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values:
  - grant=0, busy=0, err=0, burst_cnt=0, state=IDLE.
  - last_owner=N_REQ-1, so producer 0 has top priority after reset.
  - ack, w_en and data_w follow combinationally and are 0 while grant=0.
- FSM states: IDLE, SERVE.
- IDLE:
  - If any req bit is set, pick the first set bit searching last_owner+1, last_owner+2, ... modulo N_REQ.
  - Register it into grant, set burst_cnt=0, go to SERVE.
  - Otherwise stay in IDLE.
  - Latency: req rises in cycle t -> grant in t+1 -> earliest w_en in t+1.
- SERVE, with g the owner index:
  - Transfer condition: xfer = req[g] & ~full.
  - w_en = xfer; ack[g] = xfer; data_w = req_data[g] byte (0 when no grant).
  - Each xfer increments burst_cnt.
- SERVE exit occurs when either:
  - xfer with burst_cnt==BURST_MAX-1 (burst done), or
  - ~req[g] (producer withdrew; no transfer that cycle).
- On exit:
  - last_owner <= g.
  - If any other or same request is pending, re-arbitrate in the same edge from g+1 and stay in SERVE with burst_cnt=0. This gives back-to-back grants with no idle cycle.
  - If nothing is pending, grant=0 and go to IDLE.
- Full stall:
  - While full=1 in SERVE: w_en=0, ack=0, burst_cnt holds, grant holds.
  - No rotation on full; a producer is not penalised by backpressure.
- Producers must hold req and data stable until ack. Dropping req before ack is legal and ends the grant.
- Withdrawal has priority over burst completion; they cannot coincide because withdrawal implies no xfer.
- The arbiter never asserts w_en while full=1. Therefore overflow=1 indicates an external fault:
  - err <= 1 and holds until rst.
  - Arbitration continues unaffected.
- Wrap-around: last_owner search wraps modulo N_REQ; burst_cnt width is ceil(log2(BURST_MAX)), minimum 1 bit.
- BURST_MAX=1: every xfer rotates the grant.
- Reset mid-burst:
  - All state clears immediately (asynchronous); w_en drops in the same cycle.
  - No partial byte is counted as acked.

Test Plan:
- Reset, then req=0001, data0=0xA5 held for 6 cycles, full=0:
  - grant=0001 one cycle after req.
  - Bytes on cycles 1-4 ack'd (w_en=1, data_w=0xA5).
  - Grant re-issued to producer 0 with no gap since no other requester; acks continue.
- req=1111 constant, BURST_MAX=4:
  - Grants cycle 0001,0010,0100,1000,0001.
  - Exactly 4 acks per owner, no idle cycles between bursts.
  - 16 w_en pulses in 16 cycles after the first grant.
- Owner 1 mid-burst (2 bytes sent), full=1 for 3 cycles:
  - w_en=0, grant stays 0010, burst_cnt stays 2.
  - After full drops, exactly 2 more bytes from producer 1, then rotation.
- Owner 2 drops req after 1 byte while req[3]=1:
  - Next edge grant=1000.
  - Producer 2 received exactly 1 ack.
- Force overflow=1 for one cycle:
  - err=1 from the next cycle and remains 1 through continued traffic.
  - err clears only on rst=1.
- Assert rst for a partial cycle mid-burst:
  - grant, w_en, ack go 0 immediately.
  - After release with req=0110, the first grant is 0010 (producer 1, since priority restarts at 0).
